// File: rtl/uart_rx_frame_fifo_pkg.sv
// Shared UART RX definitions: payload width, stored-entry flag positions and
// the drop-counter type with its saturating increment.
package uart_rx_frame_fifo_pkg;

    localparam int UART_DATA_WIDTH = 8;

    // Error flags sit directly above the payload in a stored entry.
    localparam int PERR_BIT     = UART_DATA_WIDTH;
    localparam int FERR_BIT     = UART_DATA_WIDTH + 1;
    localparam int ENTRY_FLAG_W = 2;

    localparam int DROP_CNT_W = 8;

    typedef logic [DROP_CNT_W-1:0] drop_cnt_t;

    localparam drop_cnt_t DROP_CNT_ONE = drop_cnt_t'(1);

    // Counter increment that sticks at all-ones instead of wrapping.
    function automatic drop_cnt_t drop_cnt_sat_inc(input drop_cnt_t cnt);
        return (cnt == '1) ? cnt : cnt + DROP_CNT_ONE;
    endfunction

endpackage

// File: rtl/uart_rx_frame_fifo_if.sv
// Frame-in / host-read bundle of the UART RX frame FIFO.
// slave: the FIFO side. master: the deserializer/host side driving it.
interface uart_rx_frame_fifo_if
    import uart_rx_frame_fifo_pkg::*;
#(
    parameter int DATA_WIDTH = UART_DATA_WIDTH,
    parameter int ADDR_W     = 3
);

    // Frame capture side
    logic [DATA_WIDTH-1:0] frame_data;
    logic                  frame_done;
    logic                  parity_err;
    logic                  stop_err;

    // Host read side
    logic                  rd_ready;
    logic                  rd_valid;
    logic [DATA_WIDTH-1:0] rd_data;
    logic                  rd_perr;
    logic                  rd_ferr;

    // Status
    logic [ADDR_W:0]       level;
    logic                  full;
    logic                  empty;
    logic                  overflow;
    logic                  clr_overflow;
    drop_cnt_t             drop_cnt;

    modport slave (
        input  frame_data, frame_done, parity_err, stop_err, rd_ready, clr_overflow,
        output rd_valid, rd_data, rd_perr, rd_ferr, level, full, empty, overflow, drop_cnt
    );

    modport master (
        output frame_data, frame_done, parity_err, stop_err, rd_ready, clr_overflow,
        input  rd_valid, rd_data, rd_perr, rd_ferr, level, full, empty, overflow, drop_cnt
    );

endinterface

// File: rtl/uart_rx_fifo_mem.sv
// DEPTH x WIDTH register array for the RX frame FIFO: cleared on reset,
// one synchronous write port, one combinational read port.
module uart_rx_fifo_mem #(
    parameter int WIDTH  = 10,
    parameter int DEPTH  = 8,
    parameter int ADDR_W = 3
) (
    input  logic              clk2,
    input  logic              rst,
    input  logic              we,
    input  logic [ADDR_W-1:0] waddr,
    input  logic [WIDTH-1:0]  wdata,
    input  logic [ADDR_W-1:0] raddr,
    output logic [WIDTH-1:0]  rdata
);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [WIDTH-1:0] mem_d [DEPTH];

    // Next array contents: only the addressed word changes on a write.
    always_comb begin
        mem_d = mem_q;
        if (we) begin
            mem_d[waddr] = wdata;
        end
    end

    // Storage registers, zeroed by the asynchronous reset.
    always_ff @(posedge clk2 or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
        end else begin
            mem_q <= mem_d;
        end
    end

    assign rdata = mem_q[raddr];

endmodule

// File: rtl/uart_rx_frame_fifo.sv
// UART RX frame FIFO: stores {stop_err, parity_err, data} on each frame_done
// strobe and presents the oldest entry to the host first-word-fall-through.
// Tracks fill level, a sticky overflow flag and a saturating drop counter.
module uart_rx_frame_fifo
    import uart_rx_frame_fifo_pkg::*;
#(
    parameter int DATA_WIDTH = UART_DATA_WIDTH,
    parameter int DEPTH      = 8,
    parameter int ADDR_W     = 3,
    parameter int DROP_ERR   = 0
) (
    input logic                 clk2,
    input logic                 rst,
    uart_rx_frame_fifo_if.slave bus
);

    localparam int              ENTRY_W     = DATA_WIDTH + ENTRY_FLAG_W;
    localparam int              PERR_IDX    = DATA_WIDTH + (PERR_BIT - UART_DATA_WIDTH);
    localparam int              FERR_IDX    = DATA_WIDTH + (FERR_BIT - UART_DATA_WIDTH);
    localparam logic            DROP_ERR_EN = (DROP_ERR != 0);
    localparam logic [ADDR_W:0] PTR_ONE     = (ADDR_W+1)'(1);

    // Pointers carry one extra wrap bit so full and empty are distinguishable.
    logic [ADDR_W:0] wr_ptr_q, wr_ptr_d;
    logic [ADDR_W:0] rd_ptr_q, rd_ptr_d;
    logic [ADDR_W:0] level_q,  level_d;
    logic            overflow_q, overflow_d;
    drop_cnt_t       drop_cnt_q, drop_cnt_d;

    logic               full;
    logic               empty;
    logic               rd_valid;
    logic               pop;
    logic               frame_bad;
    logic               push_req;
    logic               push;
    logic               ovf_evt;
    logic [ENTRY_W-1:0] wr_entry;
    logic [ENTRY_W-1:0] rd_entry;

    assign full  = (wr_ptr_q[ADDR_W-1:0] == rd_ptr_q[ADDR_W-1:0]) &&
                   (wr_ptr_q[ADDR_W] != rd_ptr_q[ADDR_W]);
    assign empty = (wr_ptr_q == rd_ptr_q);

    assign rd_valid  = !empty;
    assign pop       = rd_valid && bus.rd_ready;
    assign frame_bad = bus.parity_err || bus.stop_err;
    // Errored frames filtered out here never count as overflow.
    assign push_req  = bus.frame_done && !(DROP_ERR_EN && frame_bad);
    // A pop in the same cycle frees the head slot, so a full FIFO still accepts.
    assign push      = push_req && (!full || pop);
    assign ovf_evt   = push_req && full && !pop;

    // Pack the incoming frame into a storage entry.
    always_comb begin
        wr_entry                   = '0;
        wr_entry[DATA_WIDTH-1:0]   = bus.frame_data;
        wr_entry[PERR_IDX]         = bus.parity_err;
        wr_entry[FERR_IDX]         = bus.stop_err;
    end

    uart_rx_fifo_mem #(
        .WIDTH  (ENTRY_W),
        .DEPTH  (DEPTH),
        .ADDR_W (ADDR_W)
    ) u_mem (
        .clk2   (clk2),
        .rst    (rst),
        .we     (push),
        .waddr  (wr_ptr_q[ADDR_W-1:0]),
        .wdata  (wr_entry),
        .raddr  (rd_ptr_q[ADDR_W-1:0]),
        .rdata  (rd_entry)
    );

    // Pointer and level update; simultaneous push and pop leave level unchanged.
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        level_d  = level_q;
        if (push) begin
            wr_ptr_d = wr_ptr_q + PTR_ONE;
        end
        if (pop) begin
            rd_ptr_d = rd_ptr_q + PTR_ONE;
        end
        if (push && !pop) begin
            level_d = level_q + PTR_ONE;
        end else if (pop && !push) begin
            level_d = level_q - PTR_ONE;
        end
    end

    // Overflow bookkeeping; a lost frame outranks a clear in the same cycle.
    always_comb begin
        overflow_d = overflow_q;
        drop_cnt_d = drop_cnt_q;
        if (ovf_evt) begin
            overflow_d = 1'b1;
            drop_cnt_d = bus.clr_overflow ? DROP_CNT_ONE : drop_cnt_sat_inc(drop_cnt_q);
        end else if (bus.clr_overflow) begin
            overflow_d = 1'b0;
            drop_cnt_d = '0;
        end
    end

    // Control registers, cleared by the asynchronous reset.
    always_ff @(posedge clk2 or negedge rst) begin
        if (!rst) begin
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            level_q    <= '0;
            overflow_q <= 1'b0;
            drop_cnt_q <= '0;
        end else begin
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            level_q    <= level_d;
            overflow_q <= overflow_d;
            drop_cnt_q <= drop_cnt_d;
        end
    end

    assign bus.rd_valid = rd_valid;
    assign bus.rd_data  = rd_entry[DATA_WIDTH-1:0];
    assign bus.rd_perr  = rd_entry[PERR_IDX];
    assign bus.rd_ferr  = rd_entry[FERR_IDX];
    assign bus.level    = level_q;
    assign bus.full     = full;
    assign bus.empty    = empty;
    assign bus.overflow = overflow_q;
    assign bus.drop_cnt = drop_cnt_q;

endmodule

// File: tb/tb_uart_rx_frame_fifo.sv
// Bench for uart_rx_frame_fifo: two instances (errored frames kept / dropped)
// driven in lockstep and compared every cycle against a queue-based model.
module tb_uart_rx_frame_fifo;
    import uart_rx_frame_fifo_pkg::*;

    localparam int DW    = 8;
    localparam int DEPTH = 8;
    localparam int AW    = 3;

    logic clk2 = 1'b0;
    logic rst  = 1'b1;
    int   n_cmp = 0;
    int   n_bad = 0;

    always #5 clk2 = ~clk2;

    uart_rx_frame_fifo_if #(.DATA_WIDTH(DW), .ADDR_W(AW)) if0 ();
    uart_rx_frame_fifo_if #(.DATA_WIDTH(DW), .ADDR_W(AW)) if1 ();

    uart_rx_frame_fifo #(.DATA_WIDTH(DW), .DEPTH(DEPTH), .ADDR_W(AW), .DROP_ERR(0)) dut0 (
        .clk2 (clk2),
        .rst  (rst),
        .bus  (if0)
    );

    uart_rx_frame_fifo #(.DATA_WIDTH(DW), .DEPTH(DEPTH), .ADDR_W(AW), .DROP_ERR(1)) dut1 (
        .clk2 (clk2),
        .rst  (rst),
        .bus  (if1)
    );

    // Reference model: one queue of {ferr, perr, data} per instance.
    logic [9:0] mq0[$];
    logic [9:0] mq1[$];
    logic       mov[2];
    int         mdc[2];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    function automatic int msize(input int k);
        return (k == 0) ? mq0.size() : mq1.size();
    endfunction

    function automatic logic [9:0] mhead(input int k);
        return (k == 0) ? mq0[0] : mq1[0];
    endfunction

    task automatic model_reset();
        mq0.delete();
        mq1.delete();
        mov[0] = 1'b0; mov[1] = 1'b0;
        mdc[0] = 0;    mdc[1] = 0;
    endtask

    task automatic model_edge(input int k, input logic [7:0] fd, input logic done,
                              input logic pe, input logic se, input logic rdy, input logic clr);
        int sz    = msize(k);
        bit do_pop = (sz > 0) && rdy;
        bit req    = done && !((k == 1) && (pe || se));
        bit lost   = req && (sz == DEPTH) && !do_pop;
        if (do_pop) begin
            if (k == 0) void'(mq0.pop_front());
            else        void'(mq1.pop_front());
        end
        if (req && !lost) begin
            if (k == 0) mq0.push_back({se, pe, fd});
            else        mq1.push_back({se, pe, fd});
        end
        if (lost) begin
            mov[k] = 1'b1;
            mdc[k] = clr ? 1 : ((mdc[k] < 255) ? mdc[k] + 1 : 255);
        end else if (clr) begin
            mov[k] = 1'b0;
            mdc[k] = 0;
        end
    endtask

    task automatic chk_inst(input int k, input logic rv, input logic [7:0] rd, input logic pe,
                            input logic fe, input logic [3:0] lvl, input logic fl, input logic em,
                            input logic ov, input logic [7:0] dc);
        int         sz = msize(k);
        logic [9:0] hd;
        chk($sformatf("i%0d_rd_valid", k), 32'(rv),  32'(sz > 0));
        chk($sformatf("i%0d_level", k),    32'(lvl), 32'(sz));
        chk($sformatf("i%0d_full", k),     32'(fl),  32'(sz == DEPTH));
        chk($sformatf("i%0d_empty", k),    32'(em),  32'(sz == 0));
        chk($sformatf("i%0d_overflow", k), 32'(ov),  32'(mov[k]));
        chk($sformatf("i%0d_drop_cnt", k), 32'(dc),  32'(mdc[k]));
        if (sz > 0) begin
            hd = mhead(k);
            chk($sformatf("i%0d_rd_data", k), 32'(rd), 32'(hd[7:0]));
            chk($sformatf("i%0d_rd_perr", k), 32'(pe), 32'(hd[8]));
            chk($sformatf("i%0d_rd_ferr", k), 32'(fe), 32'(hd[9]));
        end
    endtask

    task automatic check_all();
        chk_inst(0, if0.rd_valid, if0.rd_data, if0.rd_perr, if0.rd_ferr, if0.level,
                 if0.full, if0.empty, if0.overflow, if0.drop_cnt);
        chk_inst(1, if1.rd_valid, if1.rd_data, if1.rd_perr, if1.rd_ferr, if1.level,
                 if1.full, if1.empty, if1.overflow, if1.drop_cnt);
    endtask

    task automatic drive(input logic [7:0] fd, input logic done, input logic pe,
                         input logic se, input logic rdy, input logic clr);
        if0.frame_data = fd;  if1.frame_data = fd;
        if0.frame_done = done; if1.frame_done = done;
        if0.parity_err = pe;  if1.parity_err = pe;
        if0.stop_err   = se;  if1.stop_err   = se;
        if0.rd_ready   = rdy; if1.rd_ready   = rdy;
        if0.clr_overflow = clr; if1.clr_overflow = clr;
    endtask

    // One clock: drive inputs, advance the model, check one step after the edge.
    task automatic step(input logic [7:0] fd, input logic done, input logic pe,
                        input logic se, input logic rdy, input logic clr);
        drive(fd, done, pe, se, rdy, clr);
        model_edge(0, fd, done, pe, se, rdy, clr);
        model_edge(1, fd, done, pe, se, rdy, clr);
        @(posedge clk2);
        #1;
        check_all();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, got no finish, expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [7:0] rfd;
        logic       rdone, rpe, rse, rrdy, rclr;

        drive(8'h00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        model_reset();
        #1 rst = 1'b0;
        #2;
        chk("rst_rd_valid", 32'(if0.rd_valid), 32'd0);
        chk("rst_empty",    32'(if0.empty),    32'd1);
        chk("rst_full",     32'(if0.full),     32'd0);
        chk("rst_level",    32'(if0.level),    32'd0);
        chk("rst_overflow", 32'(if0.overflow), 32'd0);
        chk("rst_drop_cnt", 32'(if0.drop_cnt), 32'd0);
        chk("rst_rd_data",  32'(if0.rd_data),  32'd0);
        chk("rst_rd_flags", 32'({if0.rd_ferr, if0.rd_perr}), 32'd0);
        @(negedge clk2);
        rst = 1'b1;

        // Single frame, then pop it.
        step(8'hA5, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        chk("a5_rd_valid", 32'(if0.rd_valid), 32'd1);
        chk("a5_rd_data",  32'(if0.rd_data),  32'hA5);
        chk("a5_level",    32'(if0.level),    32'd1);
        step(8'h00, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
        chk("a5_pop_empty", 32'(if0.empty), 32'd1);

        // Fill to DEPTH.
        for (int i = 1; i <= DEPTH; i++) step(8'(i), 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        chk("fill_full",  32'(if0.full),  32'd1);
        chk("fill_level", 32'(if0.level), 32'd8);
        chk("fill_head",  32'(if0.rd_data), 32'h01);

        // Three drops while full, then overflow coinciding with a clear, then a plain clear.
        repeat (3) step(8'hEE, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        chk("ovf_flag",  32'(if0.overflow), 32'd1);
        chk("ovf_cnt",   32'(if0.drop_cnt), 32'd3);
        chk("ovf_head",  32'(if0.rd_data),  32'h01);
        chk("ovf_level", 32'(if0.level),    32'd8);
        step(8'hEE, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1);
        chk("ovf_clr_race_flag", 32'(if0.overflow), 32'd1);
        chk("ovf_clr_race_cnt",  32'(if0.drop_cnt), 32'd1);
        step(8'h00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
        chk("clr_flag", 32'(if0.overflow), 32'd0);
        chk("clr_cnt",  32'(if0.drop_cnt), 32'd0);

        // Full with push and pop together, then drain in order.
        step(8'h5A, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0);
        chk("fullpp_level", 32'(if0.level),    32'd8);
        chk("fullpp_ovf",   32'(if0.overflow), 32'd0);
        for (int j = 0; j < DEPTH; j++) begin
            chk($sformatf("drain_%0d", j), 32'(if0.rd_data), (j < 7) ? 32'(j + 2) : 32'h5A);
            step(8'h00, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
        end
        chk("drain_empty", 32'(if0.empty), 32'd1);

        // Parity-errored frame: kept by instance 0, discarded by instance 1.
        step(8'h33, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
        chk("perr_keep_flag", 32'(if0.rd_perr),  32'd1);
        chk("perr_keep_data", 32'(if0.rd_data),  32'h33);
        chk("perr_drop_level", 32'(if1.level),   32'd0);
        chk("perr_drop_ovf",  32'(if1.overflow), 32'd0);
        step(8'h00, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);

        // Randomized traffic: slow reader first (overflow pressure), fast reader after.
        for (int c = 0; c < 400; c++) begin
            rfd   = 8'($urandom);
            rdone = ($urandom_range(0, 1) == 1);
            rpe   = ($urandom_range(0, 7) == 0);
            rse   = ($urandom_range(0, 7) == 0);
            rrdy  = (c < 200) ? ($urandom_range(0, 3) == 0) : ($urandom_range(0, 3) != 0);
            rclr  = ($urandom_range(0, 31) == 0);
            step(rfd, rdone, rpe, rse, rrdy, rclr);
        end

        // Drain, pump 20 frames with interleaved pops, then reset mid-stream.
        repeat (DEPTH) step(8'h00, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
        for (int i = 0; i < 20; i++) step(8'(8'h40 + i), 1'b1, 1'b0, 1'b0, (i % 4) != 0, 1'b0);
        drive(8'h99, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        rst = 1'b0;
        model_reset();
        #1;
        chk("mid_rst_valid", 32'(if0.rd_valid), 32'd0);
        chk("mid_rst_level", 32'(if0.level),    32'd0);
        chk("mid_rst_empty", 32'(if0.empty),    32'd1);
        check_all();
        @(negedge clk2);
        rst = 1'b1;
        step(8'h77, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        chk("post_rst_data",  32'(if0.rd_data), 32'h77);
        chk("post_rst_level", 32'(if0.level),   32'd1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
